// File: rtl/shift_right_iter_pkg.sv
// Shared FPU definitions for the iterative right shifter: datapath width,
// stage count and the sequencer state encoding.
package shift_right_iter_pkg;

  localparam int WIDTH  = 32;
  localparam int STAGES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_iter_rs.sv
// One binary-weighted right-shift stage: shifts by the single weight selected
// in the one-hot amount and reports whether any discarded bit was set.
module rs_stage
  import shift_right_iter_pkg::*;
(
  input  logic [WIDTH-1:0]  data,
  input  logic              fill,
  input  logic [STAGES-1:0] amt,
  input  logic              en,
  output logic [WIDTH-1:0]  result,
  output logic              lost
);

  // NOTE: every output gets a default before the case, so no latch is inferred.
  always_comb begin
    result = data;
    lost   = 1'b0;
    if (en) begin
      unique case (amt)
        5'b10000: begin result = {{16{fill}}, data[31:16]}; lost = |data[15:0]; end
        5'b01000: begin result = {{8{fill}},  data[31:8]};  lost = |data[7:0];  end
        5'b00100: begin result = {{4{fill}},  data[31:4]};  lost = |data[3:0];  end
        5'b00010: begin result = {{2{fill}},  data[31:2]};  lost = |data[1:0];  end
        5'b00001: begin result = {fill,       data[31:1]};  lost = data[0];     end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_right_iter.sv
// Iterative 32-bit logical/arithmetic right shifter with sticky bit; one
// stage per cycle (weights 16,8,4,2,1) under a start/done handshake.
module shift_right_iter
  import shift_right_iter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  indata,
  input  logic [STAGES-1:0] shift,
  input  logic              arith,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  outdata,
  output logic              sticky
);

  state_t            state;
  logic [2:0]        k;
  logic [STAGES-1:0] amt_q;
  logic              sign_q;

  logic [2:0]        bit_idx;
  logic              stage_en;
  logic [STAGES-1:0] stage_amt;
  logic [WIDTH-1:0]  stage_data;
  logic              stage_lost;
  logic              accept;

  // Stage k consumes amount bit 4-k, so the largest weight is applied first.
  assign bit_idx   = 3'(STAGES - 1) - k;
  assign stage_en  = (state == SHIFT) && amt_q[bit_idx];
  assign stage_amt = stage_en ? (STAGES'(1) << bit_idx) : '0;

  // A start seen in the DONE cycle is taken directly so that held-high
  // requests are accepted every six cycles.
  assign accept = start && (state == IDLE || state == DONE);

  rs_stage u_stage (
    .data   (outdata),
    .fill   (sign_q),
    .amt    (stage_amt),
    .en     (stage_en),
    .result (stage_data),
    .lost   (stage_lost)
  );

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous and wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      amt_q   <= '0;
      sign_q  <= 1'b0;
      outdata <= '0;
      sticky  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        outdata <= indata;
        amt_q   <= shift;
        sign_q  <= arith & indata[WIDTH-1];
        sticky  <= 1'b0;
        k       <= '0;
        busy    <= 1'b1;
        state   <= SHIFT;
      end else begin
        unique case (state)
          SHIFT: begin
            outdata <= stage_data;
            sticky  <= sticky | stage_lost;
            k       <= k + 3'd1;
            if (k == 3'(STAGES - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_right_iter.sv
// Self-checking bench for shift_right_iter: directed corner cases, handshake
// timing, abort/ignore behaviour and random operands against a shift model.
module tb_shift_right_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] indata;
  logic [4:0]  shift;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] outdata;
  logic        sticky;

  int n_checks = 0;
  int n_fail   = 0;

  shift_right_iter dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .indata  (indata),
    .shift   (shift),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .outdata (outdata),
    .sticky  (sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain shift operators on the whole operand; sticky is set
  // when any of the low s bits of the operand is one.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] s, input logic a);
    logic [31:0] r;
    logic        st;
    if (a) r = 32'($signed(d) >>> s);
    else   r = d >> s;
    st = (d & ((32'd1 << s) - 32'd1)) != 32'd0;
    return {st, r};
  endfunction

  // Called #1 after an edge with the DUT idle. glitch_at > 0 pulses a
  // conflicting start that many edges after acceptance.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic a, input int glitch_at);
    int          lat;
    logic [32:0] exp;
    exp    = model(d, s, a);
    indata = d; shift = s; arith = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && lat < 12) begin
      if (lat == glitch_at) begin
        start = 1'b1; indata = ~d; shift = ~s; arith = ~a;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd6);
    check({tag, "_out"}, outdata, exp[31:0]);
    check({tag, "_sticky"}, 32'(sticky), 32'(exp[32]));
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          seen_done;
    logic [32:0] exp_a;
    logic [32:0] exp_b;

    rst = 1'b1; start = 1'b0; indata = '0; shift = '0; arith = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", outdata, 32'd0);
    check("rst_flags", {29'd0, busy, done, sticky}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("log_msb_31",  32'h8000_0000, 5'd31, 1'b0, 0);
    run_op("ari_msb_4",   32'h8000_0000, 5'd4,  1'b1, 0);
    run_op("log_msb_4",   32'h8000_0000, 5'd4,  1'b0, 0);
    run_op("log_f_2",     32'h0000_000F, 5'd2,  1'b0, 0);
    run_op("ari_ones_31", 32'hFFFF_FFFF, 5'd31, 1'b1, 0);
    run_op("shift0",      32'h1234_5678, 5'd0,  1'b0, 0);
    run_op("ari_pos_8",   32'h7F00_00FF, 5'd8,  1'b1, 0);
    run_op("ignore_start", 32'hC3A5_0F01, 5'd13, 1'b1, 3);

    // Back-to-back with start held high: second accept lands in the DONE cycle.
    exp_a  = model(32'hDEAD_BEEF, 5'd9, 1'b1);
    exp_b  = model(32'h0001_0003, 5'd1, 1'b0);
    indata = 32'hDEAD_BEEF; shift = 5'd9; arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    indata = 32'h0001_0003; shift = 5'd1; arith = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_a_lat", 32'(lat), 32'd6);
    check("b2b_a_out", outdata, exp_a[31:0]);
    check("b2b_a_sticky", 32'(sticky), 32'(exp_a[32]));
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_b_busy", {30'd0, busy, done}, 32'd2);
    lat = 1;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_b_lat", 32'(lat), 32'd6);
    check("b2b_b_out", outdata, exp_b[31:0]);
    check("b2b_b_sticky", 32'(sticky), 32'(exp_b[32]));
    @(posedge clk); #1;
    check("b2b_idle", {30'd0, busy, done}, 32'd0);

    // Abort in the third cycle of an operation.
    indata = 32'hFFFF_0001; shift = 5'd17; arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out", outdata, 32'd0);
    check("abort_flags", {29'd0, busy, done, sticky}, 32'd0);
    seen_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run_op("after_abort", 32'hFFFF_0001, 5'd17, 1'b1, 0);

    for (int i = 0; i < 20; i++) begin
      run_op("rand", $urandom, 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
